tusca_uc: RTL and testbench

- Control unit for the TUSCA datapath: sequences configuration reception, periodic DHT11 measurements, retries on failed reads and serial transmission of each good sample.
- Sits directly upstream of the datapath. Drives its command inputs (medir_dht11, receber_config, transmite_medida, conta_delay, zera_delay, gira) and consumes its status outputs (pronto_*/erro_*, fim_delay).
- Timing base is the datapath's 1 ms fim_delay tick; this block counts ticks to form the measurement interval.

---
 rtl/tusca_pkg.sv | 21 ++
 rtl/tusca_intervalo.sv | 32 +++
 rtl/tusca_uc.sv | 122 ++++++++++++
 tb/tb_tusca_uc.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tusca_pkg.sv
// Shared definitions for the TUSCA control unit: FSM state encoding and the
// DHT11 minimum sampling interval.
package tusca_pkg;

  localparam int DHT11_MIN_INTERVALO_MS = 1000;

  typedef enum logic [3:0] {
    INICIAL           = 4'd0,
    PEDE_CONFIG       = 4'd1,
    ESPERA_CONFIG     = 4'd2,
    MEDE              = 4'd3,
    ESPERA_MEDIDA     = 4'd4,
    TRANSMITE         = 4'd5,
    ESPERA_TRANSMITE  = 4'd6,
    PREPARA_INTERVALO = 4'd7,
    ESPERA_INTERVALO  = 4'd8,
    ERRO              = 4'd9,
    FIM               = 4'd15
  } estado_t;

endpackage

// File: rtl/tusca_intervalo.sv
// Millisecond tick counter for the measurement interval: clear, enable and a
// terminal-count strobe on the tick that completes INTERVALO_MS ticks.
module tusca_intervalo #(
  parameter int INTERVALO_MS = 2000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_zera,
  input  logic i_conta,
  input  logic i_tick,
  output logic o_fim
);

  localparam int CW = (INTERVALO_MS > 1) ? $clog2(INTERVALO_MS) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(INTERVALO_MS - 1);

  logic [CW-1:0] r_cnt;
  logic          w_terminal;

  assign w_terminal = i_conta && i_tick && (r_cnt == ULTIMO);
  assign o_fim      = w_terminal;

  // NOTE: reset is synchronous, so only clock is in the sensitivity list; state uses <= so all flops update together.
  always_ff @(posedge clock) begin
    if (!reset || i_zera) begin
      r_cnt <= '0;
    end else if (i_conta && i_tick) begin
      r_cnt <= w_terminal ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tusca_uc.sv
// TUSCA control unit: config fetch, periodic DHT11 reads with retries, and
// transmission of good samples. Optional macro TUSCA_UC_RECONFIG_EN enables nova_config.
module tusca_uc
  import tusca_pkg::*;
#(
  parameter int INTERVALO_MS   = 2000,
  parameter int MAX_TENTATIVAS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       fim_delay,
  input  logic       pronto_config,
  input  logic       erro_config,
  input  logic       pronto_medida,
  input  logic       erro_medida,
  input  logic       pronto_transmite_medida,
  input  logic       nova_config,
  output logic       receber_config,
  output logic       medir_dht11,
  output logic       transmite_medida,
  output logic       zera_delay,
  output logic       conta_delay,
  output logic       gira,
  output logic       erro,
  output logic [3:0] db_estado
);

  localparam int RW = $clog2(MAX_TENTATIVAS + 1);
  localparam logic [RW-1:0] TENT_MAX = RW'(MAX_TENTATIVAS);

  estado_t       r_estado;
  logic [RW-1:0] r_tentativas;
  logic [RW-1:0] w_tent_inc;
  logic          w_fim_intervalo;
  logic          w_zera_cnt;
  logic          w_nova_config;

`ifdef TUSCA_UC_RECONFIG_EN
  assign w_nova_config = nova_config;
`else
  logic w_unused_nova;
  assign w_unused_nova = nova_config;
  assign w_nova_config = 1'b0;
`endif

  assign w_tent_inc = r_tentativas + 1'b1;
  // Dropping ligar also clears the interval so a restart never inherits a partial count.
  assign w_zera_cnt = (r_estado == PREPARA_INTERVALO) || !ligar;

  tusca_intervalo #(
    .INTERVALO_MS(INTERVALO_MS)
  ) u_intervalo (
    .clock  (clock),
    .reset  (reset),
    .i_zera (w_zera_cnt),
    .i_conta(r_estado == ESPERA_INTERVALO),
    .i_tick (fim_delay),
    .o_fim  (w_fim_intervalo)
  );

  always_ff @(posedge clock) begin
    if (!reset || !ligar) begin
      r_estado     <= INICIAL;
      r_tentativas <= '0;
    end else begin
      case (r_estado)
        INICIAL:          r_estado <= PEDE_CONFIG;
        PEDE_CONFIG:      r_estado <= ESPERA_CONFIG;
        ESPERA_CONFIG: begin
          if (erro_config)        r_estado <= PEDE_CONFIG;
          else if (pronto_config) r_estado <= MEDE;
        end
        MEDE:             r_estado <= ESPERA_MEDIDA;
        ESPERA_MEDIDA: begin
          if (erro_medida) begin
            r_tentativas <= w_tent_inc;
            r_estado     <= (w_tent_inc == TENT_MAX) ? ERRO : PREPARA_INTERVALO;
          end else if (pronto_medida) begin
            r_tentativas <= '0;
            r_estado     <= TRANSMITE;
          end
        end
        TRANSMITE:        r_estado <= ESPERA_TRANSMITE;
        ESPERA_TRANSMITE: if (pronto_transmite_medida) r_estado <= PREPARA_INTERVALO;
        PREPARA_INTERVALO: r_estado <= ESPERA_INTERVALO;
        ESPERA_INTERVALO: begin
          if (w_nova_config)        r_estado <= PEDE_CONFIG;
          else if (w_fim_intervalo) r_estado <= MEDE;
        end
        ERRO:             r_estado <= ERRO;
        default:          r_estado <= INICIAL;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no state path can infer a latch.
    receber_config   = 1'b0;
    medir_dht11      = 1'b0;
    transmite_medida = 1'b0;
    zera_delay       = 1'b0;
    conta_delay      = 1'b0;
    gira             = 1'b0;
    erro             = 1'b0;
    case (r_estado)
      PEDE_CONFIG:       begin receber_config   = 1'b1; gira = 1'b1; end
      ESPERA_CONFIG:     gira = 1'b1;
      MEDE:              begin medir_dht11      = 1'b1; gira = 1'b1; end
      ESPERA_MEDIDA:     gira = 1'b1;
      TRANSMITE:         begin transmite_medida = 1'b1; gira = 1'b1; end
      ESPERA_TRANSMITE:  gira = 1'b1;
      PREPARA_INTERVALO: begin zera_delay       = 1'b1; gira = 1'b1; end
      ESPERA_INTERVALO:  begin conta_delay      = 1'b1; gira = 1'b1; end
      ERRO:              erro = 1'b1;
      default:           ;
    endcase
  end

  assign db_estado = r_estado;

endmodule

// File: tb/tb_tusca_uc.sv
// Directed bench for tusca_uc: a per-cycle vector table for the handshake
// paths, then hand sequences for interval timing, retries, fatal error and abort.
module tb_tusca_uc;

  logic       clock = 1'b0;
  logic       reset, ligar, fim_delay;
  logic       pronto_config, erro_config, pronto_medida, erro_medida;
  logic       pronto_transmite_medida, nova_config;
  logic       receber_config, medir_dht11, transmite_medida;
  logic       zera_delay, conta_delay, gira, erro;
  logic [3:0] db_estado;

  always #5 clock = ~clock;

  tusca_uc #(
    .INTERVALO_MS  (4),
    .MAX_TENTATIVAS(3)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .ligar                  (ligar),
    .fim_delay              (fim_delay),
    .pronto_config          (pronto_config),
    .erro_config            (erro_config),
    .pronto_medida          (pronto_medida),
    .erro_medida            (erro_medida),
    .pronto_transmite_medida(pronto_transmite_medida),
    .nova_config            (nova_config),
    .receber_config         (receber_config),
    .medir_dht11            (medir_dht11),
    .transmite_medida       (transmite_medida),
    .zera_delay             (zera_delay),
    .conta_delay            (conta_delay),
    .gira                   (gira),
    .erro                   (erro),
    .db_estado              (db_estado)
  );

  // in  = {reset, ligar, pronto_config, erro_config, pronto_medida, erro_medida, pronto_transmite}
  // out = {receber_config, medir_dht11, transmite_medida, zera_delay, conta_delay, gira, erro}
  typedef struct {
    logic [6:0] in;
    logic [3:0] est;
    logic [6:0] out;
  } vec_t;

  localparam int N_VEC = 20;
  localparam int P_PC = 0, P_EC = 1, P_PM = 2, P_EM = 3, P_PT = 4, P_NC = 5;
  localparam int O_RC = 0, O_MD = 1, O_TM = 2;

  vec_t vecs[N_VEC];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, fim_cnt = 0, n_rc = 0, n_md = 0, long_pulse = 0;
  int   n_rc0, n_md0;
  logic fim_en = 1'b0, fim_edge = 1'b0;
  logic prev_rc = 1'b0, prev_md = 1'b0, prev_tm = 1'b0, prev_zd = 1'b0;
  logic [6:0] act;

  function automatic vec_t v(input logic [6:0] in, input logic [3:0] est, input logic [6:0] out);
    vec_t r;
    r.in  = in;
    r.est = est;
    r.out = out;
    return r;
  endfunction

  function automatic logic [6:0] outs();
    return {receber_config, medir_dht11, transmite_medida, zera_delay, conta_delay, gira, erro};
  endfunction

  function automatic logic out_sel(input int w);
    case (w)
      O_RC:    return receber_config;
      O_MD:    return medir_dht11;
      default: return transmite_medida;
    endcase
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // One clock: tally pulses and fim_delay ticks seen since the last zera_delay.
  task automatic step();
    @(posedge clock);
    #1;
    fim_edge = fim_delay;
    if (fim_delay && !prev_zd) fim_cnt++;
    if (zera_delay) fim_cnt = 0;
    if (receber_config && !prev_rc) n_rc++;
    if (medir_dht11 && !prev_md) n_md++;
    if ((receber_config && prev_rc) || (medir_dht11 && prev_md) ||
        (transmite_medida && prev_tm)) long_pulse++;
    prev_rc = receber_config;
    prev_md = medir_dht11;
    prev_tm = transmite_medida;
    prev_zd = zera_delay;
    cyc++;
    fim_delay = fim_en && (cyc % 10 == 0);
  endtask

  task automatic pulse(input int which);
    case (which)
      P_PC:    pronto_config = 1'b1;
      P_EC:    erro_config = 1'b1;
      P_PM:    pronto_medida = 1'b1;
      P_EM:    erro_medida = 1'b1;
      P_PT:    pronto_transmite_medida = 1'b1;
      default: nova_config = 1'b1;
    endcase
    step();
    {pronto_config, erro_config, pronto_medida, erro_medida,
     pronto_transmite_medida, nova_config} = '0;
  endtask

  task automatic wait_out(input int which, input string name);
    for (int i = 0; i < 300 && !out_sel(which); i++) step();
    check(name, int'(out_sel(which)), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got time limit expired, required self-termination");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; ligar = 1'b0; fim_delay = 1'b0;
    {pronto_config, erro_config, pronto_medida, erro_medida,
     pronto_transmite_medida, nova_config} = '0;

    vecs[0]  = v(7'b0100000, 4'd0, 7'b0000000);  // reset dominates ligar
    vecs[1]  = v(7'b0100000, 4'd0, 7'b0000000);
    vecs[2]  = v(7'b1100000, 4'd1, 7'b1000010);
    vecs[3]  = v(7'b1100000, 4'd2, 7'b0000010);
    vecs[4]  = v(7'b1101000, 4'd1, 7'b1000010);  // erro_config re-requests
    vecs[5]  = v(7'b1100000, 4'd2, 7'b0000010);
    vecs[6]  = v(7'b1111000, 4'd1, 7'b1000010);  // both: erro wins
    vecs[7]  = v(7'b1100000, 4'd2, 7'b0000010);
    vecs[8]  = v(7'b1100100, 4'd2, 7'b0000010);  // stray pronto_medida ignored
    vecs[9]  = v(7'b1110000, 4'd3, 7'b0100010);
    vecs[10] = v(7'b1100000, 4'd4, 7'b0000010);
    vecs[11] = v(7'b1101000, 4'd4, 7'b0000010);  // stray erro_config ignored
    vecs[12] = v(7'b1100110, 4'd7, 7'b0001010);  // both medida: erro wins
    vecs[13] = v(7'b1100000, 4'd8, 7'b0000110);
    vecs[14] = v(7'b1100000, 4'd8, 7'b0000110);
    vecs[15] = v(7'b1000100, 4'd0, 7'b0000000);  // abort, late pronto ignored
    vecs[16] = v(7'b1000010, 4'd0, 7'b0000000);
    vecs[17] = v(7'b1100000, 4'd1, 7'b1000010);
    vecs[18] = v(7'b1100000, 4'd2, 7'b0000010);
    vecs[19] = v(7'b0110000, 4'd0, 7'b0000000);  // reset beats pronto_config

    for (int i = 0; i < N_VEC; i++) begin
      {reset, ligar, pronto_config, erro_config, pronto_medida, erro_medida,
       pronto_transmite_medida} = vecs[i].in;
      step();
      check($sformatf("vec%0d_estado", i), int'(db_estado), int'(vecs[i].est));
      check($sformatf("vec%0d_outs", i), int'(outs()), int'(vecs[i].out));
    end
    {reset, ligar, pronto_config, erro_config, pronto_medida, erro_medida,
     pronto_transmite_medida} = '0;

    // Normal loop with fim_delay every 10 cycles.
    fim_en = 1'b1;
    reset = 1'b0; step(); step();
    check("a_reset_estado", int'(db_estado), 0);
    check("a_reset_outs", int'(outs()), 0);
    reset = 1'b1; ligar = 1'b1;
    n_rc0 = n_rc;
    step();
    check("a_receber", int'(receber_config), 1);
    repeat (5) step();
    check("a_receber_once", n_rc - n_rc0, 1);
    pulse(P_PC);
    check("a_medir", int'(medir_dht11), 1);
    step(); step();
    pulse(P_PM);
    check("a_transmite", int'(transmite_medida), 1);
    step();
    pulse(P_PT);
    check("a_zera", int'(zera_delay), 1);
    wait_out(O_MD, "a_medir2");
    check("a_ticks", fim_cnt, 4);
    check("a_tick_latency", int'(fim_edge), 1);

    // Retry: two failures then a good read.
    n_md0 = n_md;
    step(); pulse(P_EM);
    check("b_retry1_estado", int'(db_estado), 7);
    wait_out(O_MD, "b_medir2");
    check("b_ticks1", fim_cnt, 4);
    step(); pulse(P_EM);
    check("b_retry2_estado", int'(db_estado), 7);
    wait_out(O_MD, "b_medir3");
    check("b_ticks2", fim_cnt, 4);
    check("b_erro_low", int'(erro), 0);
    step(); pulse(P_PM);
    check("b_transmite", int'(transmite_medida), 1);
    check("b_medir_count", n_md - n_md0, 2);
    step(); pulse(P_PT);
    wait_out(O_MD, "b_medir4");

    // Fatal: three consecutive failures.
    step(); pulse(P_EM);
    check("c_fail1", int'(db_estado), 7);
    wait_out(O_MD, "c_medir2");
    step(); pulse(P_EM);
    check("c_fail2", int'(db_estado), 7);
    wait_out(O_MD, "c_medir3");
    step(); pulse(P_EM);
    check("c_estado", int'(db_estado), 9);
    check("c_erro", int'(erro), 1);
    check("c_gira", int'(gira), 0);
    repeat (15) step();
    check("c_hold", int'(db_estado), 9);
    ligar = 1'b0; step();
    check("c_off_estado", int'(db_estado), 0);
    check("c_off_erro", int'(erro), 0);

    // Abort mid-interval; retry counter must restart from zero.
    ligar = 1'b1; step();
    check("d_receber", int'(receber_config), 1);
    step(); pulse(P_PC);
    step(); pulse(P_EM);
    wait_out(O_MD, "d_medir2");
    step(); pulse(P_EM);
    check("d_retry2", int'(db_estado), 7);
    repeat (16) step();
    check("d_mid_interval", int'(db_estado), 8);
    ligar = 1'b0; step();
    check("d_abort_estado", int'(db_estado), 0);
    act = outs();
    pulse(P_PM);
    act |= outs();
    for (int i = 0; i < 20; i++) begin
      step();
      act |= outs();
    end
    check("d_quiet", int'(act), 0);
    check("d_quiet_estado", int'(db_estado), 0);
    ligar = 1'b1; step();
    check("d_reconfig", int'(receber_config), 1);
    step(); pulse(P_PC);
    check("d_medir", int'(medir_dht11), 1);
    step(); pulse(P_EM);
    check("d_retry_cleared", int'(db_estado), 7);
    wait_out(O_MD, "d_medir3");
    step(); pulse(P_PM);
    check("d_transmite", int'(transmite_medida), 1);
    step();
    check("d_espera_tx", int'(db_estado), 6);
    reset = 1'b0; step();
    check("d_reset_estado", int'(db_estado), 0);
    check("d_reset_outs", int'(outs()), 0);
    reset = 1'b1;

    // nova_config coincident with the terminal tick.
    step();
    check("e_receber", int'(receber_config), 1);
    step(); pulse(P_PC);
    step(); pulse(P_PM);
    step(); pulse(P_PT);
    for (int i = 0; i < 300 && !(fim_delay && fim_cnt == 3); i++) step();
    check("e_align", fim_cnt, 3);
    n_md0 = n_md;
    n_rc0 = n_rc;
    pulse(P_NC);
`ifdef TUSCA_UC_RECONFIG_EN
    check("e_reconfig_rc", int'(receber_config), 1);
    check("e_reconfig_md", int'(medir_dht11), 0);
    repeat (12) step();
    check("e_no_medir", n_md - n_md0, 0);
    check("e_wait_cfg", int'(db_estado), 2);
    pulse(P_PC);
    check("e_medir", int'(medir_dht11), 1);
`else
    check("e_ignored_md", int'(medir_dht11), 1);
    check("e_ignored_rc", n_rc - n_rc0, 0);
`endif
    check("z_long_pulse", long_pulse, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
